serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that reuses one `full_adder` cell over several cycles to add two WIDTH-bit operands. It captures the operands on a start request, feeds one bit pair per clock LSB-first through the cell, and holds the carry in a flip-flop between bits. When the add is finished it registers the WIDTH-bit sum and the carry-out and pulses `done`. It trades latency for area, so the datapath is one full-adder cell plus shift registers.

---
 rtl/serial_adder_ctrl.sv | 98 +++++++++
 tb/tb_serial_adder_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB-first, one bit per clock,
// with the carry held in a flip-flop between bits. Result and carry-out are registered on completion.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s, fa_co;
    logic [WIDTH-1:0] s_next;
    logic             last;

    // Returns {carry_out, sum} of a single-bit full adder.
    function automatic logic [1:0] full_adder(input logic x, input logic y, input logic ci);
        full_adder = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    always_comb begin
        {fa_co, fa_s} = full_adder(a_sh[0], b_sh[0], carry);
        // New bit enters at the MSB; written as a shift so WIDTH=1 needs no special case.
        s_next = (s_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        last   = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        s_sh  <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_next;
                    carry <= fa_co;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum  <= s_next;
                        cout <= fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=8 instance checked every cycle against a
// cycle-level behavioural model, plus a WIDTH=1 instance with directed literal checks.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic         start1, cin1, busy1, done1, cout1;
    logic [0:0]   a1, b1, sum1;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: k counts cycles since an accepted request (0 = idle,
    // 1..W = busy, W+1 = done); the result is plain integer addition.
    int           k = 0;
    logic [W:0]   res = '0;
    logic [W-1:0] msum = '0;
    logic         mcout = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            k = 0; msum = '0; mcout = 1'b0;
        end else if (k == 0) begin
            if (start) begin
                k = 1;
                res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            end
        end else if (k == W) begin
            k = W + 1;
            {mcout, msum} = res;
        end else if (k == W + 1) begin
            k = 0;
        end else begin
            k++;
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(k >= 1 && k <= W));
            check("done", 32'(done), 32'(k == W + 1));
            check("sum",  32'(sum),  32'(msum));
            check("cout", 32'(cout), 32'(mcout));
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
    // lat counts edges including the accepting edge.
    task automatic run_add(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                           output int lat, output int bcyc);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(posedge clk);
        lat = 1; bcyc = 0;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        while (!done && lat < 40) begin
            if (busy) bcyc++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic run1(input logic ia, input logic ib, input logic ic, output int lat, output int bcyc);
        a1 = ia; b1 = ib; cin1 = ic; start1 = 1'b1;
        @(posedge clk);
        lat = 1; bcyc = 0;
        @(negedge clk);
        start1 = 1'b0;
        while (!done1 && lat < 10) begin
            if (busy1) bcyc++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("w1_done_seen", 32'(done1), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, bcyc, npulse, first_idx, second_idx;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_add(8'h5A, 8'h3C, 1'b0, lat, bcyc);
        check("lat_5a3c", 32'(lat), 32'd9);
        check("busy_cycles", 32'(bcyc), 32'd8);
        check("sum_5a3c", 32'(sum), 32'h96);
        check("cout_5a3c", 32'(cout), 32'd0);
        @(negedge clk);

        run_add(8'hFF, 8'h01, 1'b0, lat, bcyc);
        check("sum_ff01", 32'(sum), 32'h00);
        check("cout_ff01", 32'(cout), 32'd1);
        @(negedge clk);
        run_add(8'hFF, 8'hFF, 1'b1, lat, bcyc);
        check("sum_ffff1", 32'(sum), 32'hFF);
        check("cout_ffff1", 32'(cout), 32'd1);
        @(negedge clk);

        // start held high, operands scrambled every cycle
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        npulse = 0; first_idx = 0; second_idx = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                npulse++;
                if (npulse == 1) begin
                    first_idx = i;
                    check("sum_held_start", 32'(sum), 32'h33);
                end
                if (npulse == 2) second_idx = i;
            end
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
        start = 1'b0;
        check("held_first_done", 32'(first_idx), 32'd9);
        check("held_gap", 32'(second_idx - first_idx), 32'd10);
        check("held_pulses", 32'(npulse), 32'd3);
        repeat (3) @(negedge clk);

        // reset at the 4th RUN edge
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        npulse = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) npulse++;
        end
        check("abort_no_done", 32'(npulse), 32'd0);
        run_add(8'h12, 8'h34, 1'b0, lat, bcyc);
        check("sum_1234", 32'(sum), 32'h46);
        check("cout_1234", 32'(cout), 32'd0);
        @(negedge clk);

        // back-to-back: second start accepted on the first IDLE edge
        run_add(8'h80, 8'h80, 1'b0, lat, bcyc);
        check("sum_8080", 32'(sum), 32'h00);
        check("cout_8080", 32'(cout), 32'd1);
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("held_sum_mid", 32'(sum), 32'h00);
        check("held_cout_mid", 32'(cout), 32'd1);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_done_seen", 32'(done), 32'd1);
        check("sum_0101", 32'(sum), 32'h03);
        check("cout_0101", 32'(cout), 32'd0);
        @(negedge clk);

        // WIDTH=1 instance
        run1(1'b1, 1'b1, 1'b1, lat, bcyc);
        check("w1_lat", 32'(lat), 32'd2);
        check("w1_busy_cycles", 32'(bcyc), 32'd1);
        check("w1_sum_111", 32'(sum1), 32'd1);
        check("w1_cout_111", 32'(cout1), 32'd1);
        @(negedge clk);
        run1(1'b0, 1'b0, 1'b0, lat, bcyc);
        check("w1_sum_000", 32'(sum1), 32'd0);
        check("w1_cout_000", 32'(cout1), 32'd0);
        @(negedge clk);

        // random stimulus with occasional resets
        for (int i = 0; i < 400; i++) begin
            start = 1'($urandom_range(0, 1));
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            reset = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        reset = 1'b0; start = 1'b0;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
